// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: clock divider, x/y counters, sync/blank decode,
// and a pixel-tick delay line that keeps sync/blank aligned with downstream pixel data.
module vga_timing_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_en,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $error("vga_timing_generator: H_TOTAL/V_TOTAL must be below 1024");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_generator: CLK_DIV must be at least 2");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_generator: PIPE_DELAY must be 0..7");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_nxt;
  logic             div_wrap;
  logic             x_last;
  logic             y_last;
  logic             hs_p0;
  logic             vs_p0;
  logic             act_p0;
  logic [2:0]       dly_p1 [PIPE_DELAY+1];

  // Stage 0: clock divider; pix_en is the pixel-rate valid for everything below
  always_comb begin
    div_wrap    = (div_cnt == DIV_W'(CLK_DIV - 1));
    div_cnt_nxt = div_wrap ? '0 : div_cnt + 1'b1;
  end

  // VGA_CLK is derived from the next count so it is in phase with div_cnt itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
      VGA_CLK <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      pix_en  <= div_wrap;
      VGA_CLK <= (div_cnt_nxt >= DIV_W'(CLK_DIV / 2));
    end
  end

  // Stage 1: raster counters, advanced on each pixel tick
  always_comb begin
    x_last = (x == 10'(H_TOTAL - 1));
    y_last = (y == 10'(V_TOTAL - 1));
  end

  // Pulses are raised one clk early (on div_wrap) so they coincide with the wrapping pix_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= div_wrap && x_last;
      frame_start <= div_wrap && x_last && y_last;
      if (pix_en) begin
        x <= x_last ? 10'd0 : x + 10'd1;
        if (x_last) begin
          y <= y_last ? 10'd0 : y + 10'd1;
        end
      end
    end
  end

  always_comb begin
    hs_p0  = !((x >= 10'(HS_START)) && (x < 10'(HS_END)));
    vs_p0  = !((y >= 10'(VS_START)) && (y < 10'(VS_END)));
    act_p0 = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
  end

  // Stage 2: {hs,vs,act} delay line; stage 0 registers the current decode, PIPE_DELAY more follow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        dly_p1[i] <= 3'b110;
      end
    end else if (pix_en) begin
      dly_p1[0] <= {hs_p0, vs_p0, act_p0};
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        dly_p1[i] <= dly_p1[i-1];
      end
    end
  end

  assign VGA_HS      = dly_p1[PIPE_DELAY][2];
  assign VGA_VS      = dly_p1[PIPE_DELAY][1];
  assign VGA_BLANK_N = dly_p1[PIPE_DELAY][0];
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator: full-size timing with PIPE_DELAY 1 and 0,
// plus a scaled-down raster for frame-level and mid-frame reset behaviour.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ab_n;
  logic rst_c_n;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_pix, a_vclk, a_hs, a_vs, a_bl, a_sn, a_ls, a_fs;
  logic b_pix, b_vclk, b_hs, b_vs, b_bl, b_sn, b_ls, b_fs;
  logic c_pix, c_vclk, c_hs, c_vs, c_bl, c_sn, c_ls, c_fs;

  vga_timing_generator #(.PIPE_DELAY(1)) dut_a (
    .clk(clk), .rst_n(rst_ab_n), .x(a_x), .y(a_y), .pix_en(a_pix), .VGA_CLK(a_vclk),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sn),
    .line_start(a_ls), .frame_start(a_fs));

  vga_timing_generator #(.PIPE_DELAY(0)) dut_b (
    .clk(clk), .rst_n(rst_ab_n), .x(b_x), .y(b_y), .pix_en(b_pix), .VGA_CLK(b_vclk),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sn),
    .line_start(b_ls), .frame_start(b_fs));

  // Small raster: H 8/2/3/2 (15), V 4/1/2/2 (9), 135 ticks per frame
  vga_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .PIPE_DELAY(2)
  ) dut_c (
    .clk(clk), .rst_n(rst_c_n), .x(c_x), .y(c_y), .pix_en(c_pix), .VGA_CLK(c_vclk),
    .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_BLANK_N(c_bl), .VGA_SYNC_N(c_sn),
    .line_start(c_ls), .frame_start(c_fs));

  typedef struct {
    int tick;
    int x;
    int y;
    bit hs, vs, bl, ls, fs;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t mk(int t, int ex, int ey, bit hs, bit vs, bit bl, bit ls, bit fs);
    exp_t e;
    e.tick = t; e.x = ex; e.y = ey;
    e.hs = hs; e.vs = vs; e.bl = bl; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  task automatic check_tick(string tag, exp_t e, logic [9:0] ax, logic [9:0] ay,
                            logic hs, logic vs, logic bl, logic ls, logic fs);
    n_cmp++;
    if (int'(ax) != e.x || int'(ay) != e.y || hs !== e.hs || vs !== e.vs ||
        bl !== e.bl || ls !== e.ls || fs !== e.fs) begin
      n_bad++;
      $display("FAIL %s@tick%0d: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
               tag, e.tick, ax, ay, hs, vs, bl, ls, fs, e.x, e.y, e.hs, e.vs, e.bl, e.ls, e.fs);
    end
  endtask

  task automatic check1(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitors: count pixel ticks since reset release and pop expected entries by tick index
  int tick_a = 0, tick_b = 0, tick_c = 0;
  int hs_low_a = 0, hs_low_b = 0, vclk_same_a = 0;
  logic a_vclk_prev = 1'b0;
  int win_bl_c = 0, win_vs_c = 0, win_hs_c = 0, win_ls_c = 0, win_fs_c = 0, fs_early_c = 0;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_ab_n) begin
      tick_a = 0;
    end else begin
      if (tick_a > 0 && a_vclk == a_vclk_prev) vclk_same_a++;
      if (a_pix) begin
        if (tick_a >= 800 && tick_a < 1600 && !a_hs) hs_low_a++;
        if (q_a.size() > 0) begin
          if (q_a[0].tick == tick_a) begin
            e = q_a.pop_front();
            check_tick("a", e, a_x, a_y, a_hs, a_vs, a_bl, a_ls, a_fs);
          end
        end
        tick_a++;
      end
    end
    a_vclk_prev = a_vclk;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_ab_n) begin
      tick_b = 0;
    end else if (b_pix) begin
      if (tick_b >= 800 && tick_b < 1600 && !b_hs) hs_low_b++;
      if (q_b.size() > 0) begin
        if (q_b[0].tick == tick_b) begin
          e = q_b.pop_front();
          check_tick("b", e, b_x, b_y, b_hs, b_vs, b_bl, b_ls, b_fs);
        end
      end
      tick_b++;
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (!rst_c_n) begin
      tick_c = 0;
      fs_early_c = 0;
      win_bl_c = 0; win_vs_c = 0; win_hs_c = 0; win_ls_c = 0; win_fs_c = 0;
    end else if (c_pix) begin
      if (tick_c < 134 && c_fs) fs_early_c++;
      if (tick_c >= 135 && tick_c < 270) begin
        if (c_bl) win_bl_c++;
        if (!c_vs) win_vs_c++;
        if (!c_hs) win_hs_c++;
        if (c_ls) win_ls_c++;
        if (c_fs) win_fs_c++;
      end
      if (q_c.size() > 0) begin
        if (q_c[0].tick == tick_c) begin
          e = q_c.pop_front();
          check_tick("c", e, c_x, c_y, c_hs, c_vs, c_bl, c_ls, c_fs);
        end
      end
      tick_c++;
    end
  end

  initial begin : stim
    int waited;
    rst_ab_n = 1'b0;
    rst_c_n  = 1'b0;

    // Full-size, PIPE_DELAY=1: outputs during tick n reflect decode of tick n-2
    q_a.push_back(mk(0,    0,   0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(1,    1,   0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(2,    2,   0, 1, 1, 1, 0, 0));
    q_a.push_back(mk(640,  640, 0, 1, 1, 1, 0, 0));
    q_a.push_back(mk(641,  641, 0, 1, 1, 1, 0, 0));
    q_a.push_back(mk(642,  642, 0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(657,  657, 0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(658,  658, 0, 0, 1, 0, 0, 0));
    q_a.push_back(mk(753,  753, 0, 0, 1, 0, 0, 0));
    q_a.push_back(mk(754,  754, 0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(799,  799, 0, 1, 1, 0, 1, 0));
    q_a.push_back(mk(800,  0,   1, 1, 1, 0, 0, 0));
    q_a.push_back(mk(801,  1,   1, 1, 1, 0, 0, 0));
    q_a.push_back(mk(802,  2,   1, 1, 1, 1, 0, 0));
    q_a.push_back(mk(1457, 657, 1, 1, 1, 0, 0, 0));
    q_a.push_back(mk(1553, 753, 1, 0, 1, 0, 0, 0));
    // Full-size, PIPE_DELAY=0: outputs during tick n reflect decode of tick n-1
    q_b.push_back(mk(0,    0,   0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(1,    1,   0, 1, 1, 1, 0, 0));
    q_b.push_back(mk(641,  641, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(656,  656, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(657,  657, 0, 0, 1, 0, 0, 0));
    q_b.push_back(mk(752,  752, 0, 0, 1, 0, 0, 0));
    q_b.push_back(mk(753,  753, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(799,  799, 0, 1, 1, 0, 1, 0));
    q_b.push_back(mk(800,  0,   1, 1, 1, 0, 0, 0));
    q_b.push_back(mk(801,  1,   1, 1, 1, 1, 0, 0));
    q_b.push_back(mk(1457, 657, 1, 0, 1, 0, 0, 0));
    q_b.push_back(mk(1553, 753, 1, 1, 1, 0, 0, 0));
    // Small raster, PIPE_DELAY=2: outputs during tick n reflect decode of tick n-3
    q_c.push_back(mk(0,   0,  0, 1, 1, 0, 0, 0));
    q_c.push_back(mk(2,   2,  0, 1, 1, 0, 0, 0));
    q_c.push_back(mk(3,   3,  0, 1, 1, 1, 0, 0));
    q_c.push_back(mk(14,  14, 0, 0, 1, 0, 1, 0));
    q_c.push_back(mk(77,  2,  5, 1, 1, 0, 0, 0));
    q_c.push_back(mk(78,  3,  5, 1, 0, 0, 0, 0));
    q_c.push_back(mk(134, 14, 8, 0, 1, 0, 1, 1));
    q_c.push_back(mk(135, 0,  0, 0, 1, 0, 0, 0));
    q_c.push_back(mk(269, 14, 8, 0, 1, 0, 1, 1));

    repeat (3) @(negedge clk);
    check1("rst_x", int'(a_x), 0);
    check1("rst_y", int'(a_y), 0);
    check1("rst_pix_en", int'(a_pix), 0);
    check1("rst_vga_clk", int'(a_vclk), 0);
    check1("rst_hs", int'(a_hs), 1);
    check1("rst_vs", int'(a_vs), 1);
    check1("rst_blank_n", int'(a_bl), 0);
    check1("rst_line_start", int'(a_ls), 0);
    check1("rst_frame_start", int'(a_fs), 0);
    check1("sync_n", int'(a_sn), 0);

    rst_ab_n = 1'b1;
    rst_c_n  = 1'b1;
    @(negedge clk);
    check1("pix_en_clk1", int'(a_pix), 0);
    check1("pre_tick_blank_n", int'(b_bl), 0);
    @(negedge clk);
    check1("pix_en_clk2", int'(a_pix), 1);
    check1("first_tick_x", int'(a_x), 0);

    waited = 0;
    while (!(tick_a > 1600 && tick_b > 1600 && tick_c > 270) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check1("phase1_in_budget", int'(waited < 5000), 1);
    check1("q_a_drained", q_a.size(), 0);
    check1("q_b_drained", q_b.size(), 0);
    check1("q_c_drained", q_c.size(), 0);
    check1("hs_low_ticks_d1", hs_low_a, 96);
    check1("hs_low_ticks_d0", hs_low_b, 96);
    check1("vga_clk_toggles", vclk_same_a, 0);
    check1("c_blank_per_frame", win_bl_c, 32);
    check1("c_vs_low_per_frame", win_vs_c, 30);
    check1("c_hs_low_per_frame", win_hs_c, 27);
    check1("c_line_starts_per_frame", win_ls_c, 9);
    check1("c_frame_starts_per_frame", win_fs_c, 1);
    check1("c_no_early_frame_start", fs_early_c, 0);

    // Mid-line reset of the full-size pair at x=300
    waited = 0;
    while (int'(a_x) != 300 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check1("reach_x300", int'(a_x), 300);
    rst_ab_n = 1'b0;
    #1;
    check1("midrst_x", int'(a_x), 0);
    check1("midrst_y", int'(a_y), 0);
    check1("midrst_hs", int'(a_hs), 1);
    check1("midrst_vs", int'(a_vs), 1);
    check1("midrst_blank_n", int'(a_bl), 0);
    check1("midrst_b_x", int'(b_x), 0);
    repeat (3) @(negedge clk);
    q_a.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0));
    rst_ab_n = 1'b1;

    // Mid-frame reset of the small raster at x=5,y=3
    waited = 0;
    while (!(int'(c_x) == 5 && int'(c_y) == 3) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check1("reach_c_x5y3", int'(waited < 1000), 1);
    rst_c_n = 1'b0;
    #1;
    check1("c_midrst_x", int'(c_x), 0);
    check1("c_midrst_y", int'(c_y), 0);
    check1("c_midrst_hs", int'(c_hs), 1);
    check1("c_midrst_blank_n", int'(c_bl), 0);
    repeat (3) @(negedge clk);
    q_c.push_back(mk(134, 14, 8, 0, 1, 0, 1, 1));
    q_c.push_back(mk(135, 0,  0, 0, 1, 0, 0, 0));
    rst_c_n = 1'b1;

    waited = 0;
    while (!(tick_c > 136 && tick_a > 3 && tick_b > 3) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check1("phase2_in_budget", int'(waited < 2000), 1);
    check1("c_no_frame_start_after_release", fs_early_c, 0);
    check1("q_a_drained_end", q_a.size(), 0);
    check1("q_b_drained_end", q_b.size(), 0);
    check1("q_c_drained_end", q_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Sits directly upstream of the sprite/pixel stage and drives its x/y pixel coordinates.
- Drives the VGA connector sync/blank/clock pins directly.
- Delays sync and blank by a configurable number of pixel ticks so they stay aligned with the one-cycle-latency sprite SRAM read data.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel (>=2)
PIPE_DELAY, 1, pixel-tick delay applied to HS/VS/BLANK_N (0..7)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
x  output  10  current pixel column, 0..H_TOTAL-1
y  output  10  current line, 0..V_TOTAL-1
pix_en  output  1  one-clk pulse, once per pixel tick
VGA_CLK  output  1  pixel clock to DAC
VGA_HS  output  1  horizontal sync, active low, delayed
VGA_VS  output  1  vertical sync, active low, delayed
VGA_BLANK_N  output  1  high in visible area, delayed
VGA_SYNC_N  output  1  constant 0 (sync-on-green unused)
line_start  output  1  one-clk pulse when x wraps to 0
frame_start  output  1  one-clk pulse when x and y both wrap to 0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release): div_cnt=0, x=0, y=0, pix_en=0, VGA_CLK=0, line_start=0, frame_start=0.
- All delay-line stages are loaded with the inactive pattern HS=1, VS=1, BLANK_N=0, so the outputs show the same values.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high for exactly the clk cycle after div_cnt==CLK_DIV-1.
  - VGA_CLK is registered and high while div_cnt >= CLK_DIV/2 (50% duty when CLK_DIV is even).
- Counters advance only on pix_en:
  - x increments; at x==H_TOTAL-1 it wraps to 0.
  - On the x wrap, y increments; at y==V_TOTAL-1 it wraps to 0.
  - x and y are registers with zero delay relative to the pixel tick.
- Decode per tick, from the current x/y:
  - hs_raw = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - act_raw = (x<H_ACTIVE) && (y<V_ACTIVE).
- Delay line:
  - Shift register of PIPE_DELAY stages for {hs,vs,act}, advancing only on pix_en.
  - At each pix_en, output = decode of the (x,y) that was current PIPE_DELAY ticks earlier.
  - With PIPE_DELAY=0, outputs are registered from the current decode on each pix_en.
  - Outputs change only on clk edges where pix_en=1.
- VGA_BLANK_N = delayed act. VGA_SYNC_N is tied to 0.
- line_start: high for the single clk cycle in which x transitions to 0 (coincides with pix_en).
- frame_start: same, but only when y also transitions to 0.
- frame_start implies line_start; both pulses follow counter timing, not delayed timing.
- Reset mid-frame: all counters and the delay line return to reset values immediately. Counting restarts at x=0,y=0.
- No frame_start is generated on reset release. The first frame_start occurs after a full frame of H_TOTAL*V_TOTAL pixel ticks.
- Widths: x and y are 10 bits; parameter sums must be < 1024 (checked by elaboration-time assertion).

Test Plan:
- Reset then release, defaults:
  - First pix_en 2 clk after release; x counts 0,1,2 on successive pix_en.
  - Before first tick: VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
- Horizontal timing, PIPE_DELAY=0:
  - VGA_HS low for exactly 96 pixel ticks, starting the tick after x==656 is decoded.
  - Period 800 ticks (1600 clk).
- Vertical and frame:
  - VGA_VS low for 2 lines (1600 ticks).
  - frame_start pulses every 420000 ticks (840000 clk), with x=0,y=0 on the following cycle.
  - line_start count between frame_starts = 525.
- PIPE_DELAY=1 vs 0: VGA_BLANK_N first rises exactly one pixel tick (2 clk) later, while x/y timing is identical.
- Active-area count: VGA_BLANK_N=1 on exactly 307200 pix_en cycles per frame.
- Reset at x=300,y=200 asserted for 3 clk:
  - x,y=0 immediately; HS/VS=1, BLANK_N=0.
  - Next frame_start arrives 420000 ticks after release.
